// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared state encoding and width constants for the square-root controller
package sqrt_pkg;

    localparam int RAD_W_DEF  = 16;
    localparam int ROOT_W_DEF = RAD_W_DEF / 2;
    localparam int REM_W_DEF  = ROOT_W_DEF + 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/sqrt_step.sv
// rtl/sqrt_step.sv - one restoring-sqrt trial: compare remainder against (root<<2)|1 and subtract
module sqrt_step #(
    parameter  int ROOT_W = 8,
    localparam int REM_W  = ROOT_W + 3
) (
    input  logic [REM_W-1:0]  rem_i,
    input  logic [ROOT_W-1:0] root_i,
    output logic [REM_W-1:0]  rem_o,
    output logic              bit_o
);

    logic [REM_W-1:0] trial;

    assign trial = {1'b0, root_i, 2'b01};
    assign bit_o = (rem_i >= trial);
    assign rem_o = bit_o ? (rem_i - trial) : rem_i;

endmodule

// File: rtl/sqrt_ctrl.sv
// rtl/sqrt_ctrl.sv - bit-serial integer square root with registered strobes for a downstream root register
module sqrt_ctrl
    import sqrt_pkg::*;
#(
    parameter  int RAD_W  = RAD_W_DEF,
    localparam int ROOT_W = RAD_W / 2,
    localparam int REM_W  = ROOT_W + 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [RAD_W-1:0]  in_A,
    output logic              busy,
    output logic              done,
    output logic [ROOT_W-1:0] root,
    output logic [ROOT_W:0]   rem,
    output logic              load,
    output logic              shift,
    output logic              load_R0,
    output logic              in_bit,
    output logic [RAD_W-1:0]  out_A
);

    localparam int CNT_W = $clog2(ROOT_W);
    localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(ROOT_W - 1);

    state_e              state_q, state_d;
    logic [RAD_W-1:0]    rad_q, rad_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic [ROOT_W-1:0]   root_q, root_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                load_q, load_d;
    logic                shift_q, shift_d;
    logic                load_r0_q, load_r0_d;
    logic                in_bit_q, in_bit_d;

    logic [REM_W-1:0]    step_rem;
    logic                step_bit;

    sqrt_step #(.ROOT_W(ROOT_W)) u_step (
        .rem_i  (rem_q),
        .root_i (root_q),
        .rem_o  (step_rem),
        .bit_o  (step_bit)
    );

    // Strobes are decoded from the current state and registered, so every
    // output moves only on a rising edge and trails the state by one cycle.
    always_comb begin
        state_d   = state_q;
        rad_d     = rad_q;
        rem_d     = rem_q;
        root_d    = root_q;
        cnt_d     = cnt_q;
        busy_d    = (state_q != S_IDLE);
        done_d    = 1'b0;
        load_d    = 1'b0;
        shift_d   = 1'b0;
        load_r0_d = 1'b0;
        in_bit_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rad_d   = in_A;
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                load_d  = 1'b1;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                shift_d = 1'b1;
                rem_d   = {rem_q[REM_W-3:0], rad_q[RAD_W-1 -: 2]};
                rad_d   = rad_q << 2;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                load_r0_d = 1'b1;
                in_bit_d  = step_bit;
                rem_d     = step_rem;
                root_d    = {root_q[ROOT_W-2:0], step_bit};
                cnt_d     = cnt_q + 1'b1;
                state_d   = (cnt_q == LAST_IT) ? S_DONE : S_SHIFT;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            rad_q     <= '0;
            rem_q     <= '0;
            root_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            load_q    <= 1'b0;
            shift_q   <= 1'b0;
            load_r0_q <= 1'b0;
            in_bit_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rad_q     <= rad_d;
            rem_q     <= rem_d;
            root_q    <= root_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            load_q    <= load_d;
            shift_q   <= shift_d;
            load_r0_q <= load_r0_d;
            in_bit_q  <= in_bit_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign root    = root_q;
    assign rem     = rem_q[ROOT_W:0];
    assign load    = load_q;
    assign shift   = shift_q;
    assign load_R0 = load_r0_q;
    assign in_bit  = in_bit_q;
    assign out_A   = '0;

endmodule

// File: tb/tb_sqrt_ctrl.sv
// tb/tb_sqrt_ctrl.sv - scoreboard bench for sqrt_ctrl against an arithmetic square-root model
module tb_sqrt_ctrl;

    localparam int RAD_W  = 16;
    localparam int ROOT_W = 8;
    localparam int LAT    = 2 * ROOT_W + 2;

    logic              clk;
    logic              reset;
    logic              start;
    logic [RAD_W-1:0]  in_A;
    logic              busy;
    logic              done;
    logic [ROOT_W-1:0] root;
    logic [ROOT_W:0]   rem;
    logic              load;
    logic              shift;
    logic              load_R0;
    logic              in_bit;
    logic [RAD_W-1:0]  out_A;

    sqrt_ctrl #(.RAD_W(RAD_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .in_A    (in_A),
        .busy    (busy),
        .done    (done),
        .root    (root),
        .rem     (rem),
        .load    (load),
        .shift   (shift),
        .load_R0 (load_R0),
        .in_bit  (in_bit),
        .out_A   (out_A)
    );

    typedef struct {
        int unsigned a;
        int unsigned root;
        int unsigned rem;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          tests   = 0;
    int          failed  = 0;
    int          cyc     = 0;
    int          nbits   = 0;
    int unsigned bits_got = 0;
    bit          end_chk  = 0;
    bit          mon_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned isqrt(input int unsigned a);
        int unsigned r;
        r = 0;
        while ((r + 1) * (r + 1) <= a) r++;
        return r;
    endfunction

    // Caller must be sitting at a falling edge with the DUT idle.
    task automatic issue(input int unsigned a, input bit expect_result);
        exp_t e;
        if (expect_result) begin
            e.a    = a;
            e.root = isqrt(a);
            e.rem  = a - e.root * e.root;
            e.due  = cyc + 1 + LAT;
            exp_q.push_back(e);
        end
        start = 1'b1;
        in_A  = a[RAD_W-1:0];
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3 * LAT; i++) begin
            @(negedge clk);
            if (done) break;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            tests++;
            if (busy || done || load || shift || load_R0 || in_bit || root != 0 || rem != 0) begin
                failed++;
                $display("FAIL reset_outputs: busy=%0b done=%0b load=%0b shift=%0b load_R0=%0b in_bit=%0b root=%0d rem=%0d, required all 0",
                         busy, done, load, shift, load_R0, in_bit, root, rem);
            end
            nbits    = 0;
            bits_got = 0;
        end else begin
            tests++;
            if (int'(load) + int'(shift) + int'(load_R0) > 1) begin
                failed++;
                $display("FAIL strobe_exclusive: load=%0b shift=%0b load_R0=%0b at cycle %0d, required at most one high",
                         load, shift, load_R0, cyc);
            end
            if (load_R0) begin
                bits_got = (bits_got << 1) | int'(in_bit);
                nbits++;
            end
            if (done) begin
                tests++;
                if (exp_q.size() == 0) begin
                    failed++;
                    $display("FAIL unexpected_done: done seen at cycle %0d, required no pulse", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(cyc) != e.due) begin
                        failed++;
                        $display("FAIL latency a=%0d: done at cycle %0d, required %0d", e.a, cyc, e.due);
                    end
                    tests++;
                    if (32'(root) != e.root || 32'(rem) != e.rem) begin
                        failed++;
                        $display("FAIL result a=%0d: root=%0d rem=%0d, required root=%0d rem=%0d",
                                 e.a, root, rem, e.root, e.rem);
                    end
                    tests++;
                    if (nbits != ROOT_W || bits_got != e.root) begin
                        failed++;
                        $display("FAIL bit_stream a=%0d: %0d bits value %0d, required %0d bits value %0d",
                                 e.a, nbits, bits_got, ROOT_W, e.root);
                    end
                    tests++;
                    if (!busy || out_A != 0) begin
                        failed++;
                        $display("FAIL busy_outA a=%0d: busy=%0b out_A=%0d, required busy=1 out_A=0", e.a, busy, out_A);
                    end
                end
                nbits    = 0;
                bits_got = 0;
            end else if (exp_q.size() > 0 && int'(cyc) > exp_q[0].due) begin
                e = exp_q.pop_front();
                tests++;
                failed++;
                $display("FAIL timeout a=%0d: no done by cycle %0d, required at %0d", e.a, cyc, e.due);
            end
        end
        if (end_chk && !mon_done) begin
            tests++;
            if (exp_q.size() != 0) begin
                failed++;
                $display("FAIL pending_results: %0d outstanding, required 0", exp_q.size());
            end
            mon_done = 1'b1;
        end
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        in_A  = '0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);

        issue(0, 1);       wait_done();
        issue(144, 1);     wait_done();
        issue(145, 1);     wait_done();
        issue(65025, 1);   wait_done();
        issue(65535, 1);   wait_done();

        // A second start while the first operation is in flight must vanish.
        issue(100, 1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        in_A  = 16'd400;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Abort mid-operation; any later done pulse shows up as unexpected.
        issue(200, 0);
        repeat (6) @(posedge clk);
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (LAT + 5) @(negedge clk);
        issue(49, 1);      wait_done();

        for (int i = 0; i < 25; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            issue($urandom_range(0, 65535), 1);
            wait_done();
        end

        repeat (5) @(negedge clk);
        end_chk = 1'b1;
        for (int i = 0; i < 10 && !mon_done; i++) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
